dual_address_ram_two_stage_pipeline: RTL

DUAL_ADDRESS_RAM_TWO_STAGE_PIPELINE -- requirements
Module: dual_address_ram_two_stage_pipeline

---
 rtl/dual_ram_pkg.sv | 8 +
 rtl/ram_port_stage.sv | 33 +++
 rtl/dual_address_ram_two_stage_pipeline.sv | 79 +++++++
 3 files changed

// File: rtl/dual_ram_pkg.sv
// Shared sizing for the dual-address RAM: geometry and collision-counter width.
package dual_ram_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/ram_port_stage.sv
// Stage-1 capture of one port's command (we/re/addr/din); cleared by reset so nothing in flight survives.
module ram_port_stage #(
  parameter int ADDR_W = dual_ram_pkg::ADDR_W,
  parameter int DATA_W = dual_ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              we_p1,
  output logic              re_p1,
  output logic [ADDR_W-1:0] addr_p1,
  output logic [DATA_W-1:0] din_p1
);

  // stage 0 -> stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p1   <= 1'b0;
      re_p1   <= 1'b0;
      addr_p1 <= '0;
      din_p1  <= '0;
    end else begin
      we_p1   <= we;
      re_p1   <= re;
      addr_p1 <= addr;
      din_p1  <= din;
    end
  end

endmodule

// File: rtl/dual_address_ram_two_stage_pipeline.sv
// Two-port RAM with a two-stage pipeline per port: read-first commit, port 1 wins
// same-address dual writes, and a saturating collision counter.
module dual_address_ram_two_stage_pipeline #(
  parameter int ADDR_W = dual_ram_pkg::ADDR_W,
  parameter int DATA_W = dual_ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we1,
  input  logic              we2,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  output logic [DATA_W-1:0] dout1,
  output logic [DATA_W-1:0] dout2,
  output logic              vld1,
  output logic              vld2,
  output logic              wr_collision,
  output logic [7:0]        coll_cnt
);
  import dual_ram_pkg::*;

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic              we1_p1, re1_p1, we2_p1, re2_p1;
  logic [ADDR_W-1:0] addr1_p1, addr2_p1;
  logic [DATA_W-1:0] din1_p1, din2_p1;
  logic              coll_p1;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  ram_port_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .clk(clk), .rst_n(rst_n), .we(we1), .re(re1), .addr(addr1), .din(din1),
    .we_p1(we1_p1), .re_p1(re1_p1), .addr_p1(addr1_p1), .din_p1(din1_p1)
  );

  ram_port_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port2 (
    .clk(clk), .rst_n(rst_n), .we(we2), .re(re2), .addr(addr2), .din(din2),
    .we_p1(we2_p1), .re_p1(re2_p1), .addr_p1(addr2_p1), .din_p1(din2_p1)
  );

  assign coll_p1 = we1_p1 && we2_p1 && (addr1_p1 == addr2_p1);

  // stage 1 -> stage 2: commit writes; port 2 is suppressed when it collides with port 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we2_p1 && !coll_p1) mem[addr2_p1] <= din2_p1;
      if (we1_p1)             mem[addr1_p1] <= din1_p1;
    end
  end

  // Reads sample mem before this edge's writes land, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout1        <= '0;
      dout2        <= '0;
      vld1         <= 1'b0;
      vld2         <= 1'b0;
      wr_collision <= 1'b0;
      coll_cnt     <= '0;
    end else begin
      vld1         <= re1_p1;
      vld2         <= re2_p1;
      wr_collision <= coll_p1;
      if (re1_p1) dout1 <= mem[addr1_p1];
      if (re2_p1) dout2 <= mem[addr2_p1];
      if (coll_p1) coll_cnt <= sat_inc(coll_cnt);
    end
  end

endmodule
